// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: coefficient loader for the transposed pipelined FIR.
// Loads FIR_DEPTH words into a shadow bank over a valid/ready port. It then
// stalls the FIR input and waits for the pipeline to drain. Finally it swaps
// the shadow bank into the active bank in a single cycle.
//
// Optional feature macro: FIR_COEFF_DRAIN_TIMEOUT_EN
//   When defined, DRAIN is bounded by DRAIN_TIMEOUT cycles, and a forced swap
//   pulses o_timeout. When undefined, o_timeout is tied low.
//
// Ports:
//   i_clk, i_rst           clock, async active-low reset
//   i_en                   global enable (freezes everything when low)
//   i_cfg_start            pulse: begin/restart a coefficient load
//   iv_cfg_data/i_cfg_valid/o_cfg_ready   coefficient stream handshake
//   i_fir_busy             FIR pipeline still holds samples
//   o_hold                 stall request for the FIR input valid
//   ov_coeff               active bank, coeff k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//   o_coeff_update         pulse in the cycle the new active bank appears
//   o_busy                 loader not idle
//   o_abort                pulse when a load is restarted mid-load
//   o_timeout              pulse on forced swap (optional feature)
module fir_coeff_loader #(
    parameter int unsigned COEFF_WIDTH   = 24,
    parameter int unsigned FIR_DEPTH     = 16,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_en,
    input  logic                             i_cfg_start,
    input  logic [COEFF_WIDTH-1:0]           iv_cfg_data,
    input  logic                             i_cfg_valid,
    output logic                             o_cfg_ready,
    input  logic                             i_fir_busy,
    output logic                             o_hold,
    output logic [FIR_DEPTH*COEFF_WIDTH-1:0] ov_coeff,
    output logic                             o_coeff_update,
    output logic                             o_busy,
    output logic                             o_abort,
    output logic                             o_timeout
);

    localparam int unsigned IDX_W = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIR_DEPTH - 1);

    // Elaboration-time parameter sanity checks
    if (FIR_DEPTH < 2) begin : g_depth_chk
        $error("fir_coeff_loader: FIR_DEPTH must be at least 2");
    end
    if (DRAIN_TIMEOUT < 2) begin : g_timeout_chk
        $error("fir_coeff_loader: DRAIN_TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [COEFF_WIDTH-1:0] shadow [FIR_DEPTH];
    // Set after the first DRAIN cycle: the hold has been seen by the FIR input
    logic                   hold_seen;
    logic                   handshake;
    logic                   to_hit;

    assign o_cfg_ready = (state == LOAD) && i_en;
    assign handshake   = i_cfg_valid && o_cfg_ready;

`ifdef FIR_COEFF_DRAIN_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(DRAIN_TIMEOUT + 1) > 8) ?
                                   $clog2(DRAIN_TIMEOUT + 1) : 8;
    logic [TO_W-1:0] to_cnt;

    // The count reaches DRAIN_TIMEOUT at the end of this cycle
    assign to_hit = i_fir_busy && (to_cnt == TO_W'(DRAIN_TIMEOUT - 1));

    // DRAIN cycle counter and forced-swap pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            to_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if (i_en) begin
                if (state == LOAD) begin
                    to_cnt <= '0;
                end else if (state == DRAIN) begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (to_hit) begin
                        o_timeout <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign to_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Main loader FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state          <= IDLE;
            idx            <= '0;
            hold_seen      <= 1'b0;
            o_hold         <= 1'b0;
            o_busy         <= 1'b0;
            o_abort        <= 1'b0;
            o_coeff_update <= 1'b0;
            ov_coeff       <= '0;
            for (int k = 0; k < FIR_DEPTH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            // Pulses clear every cycle, including while disabled
            o_abort        <= 1'b0;
            o_coeff_update <= 1'b0;
            if (i_en) begin
                case (state)
                    IDLE: begin
                        if (i_cfg_start) begin
                            state  <= LOAD;
                            idx    <= '0;
                            o_busy <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (i_cfg_start) begin
                            // Restart wins over a same-cycle handshake
                            idx     <= '0;
                            o_abort <= 1'b1;
                        end else if (handshake) begin
                            shadow[idx] <= iv_cfg_data;
                            if (idx == LAST_IDX) begin
                                state     <= DRAIN;
                                idx       <= '0;
                                o_hold    <= 1'b1;
                                hold_seen <= 1'b0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if ((hold_seen && !i_fir_busy) || to_hit) begin
                            // New bank and its update pulse appear together in SWAP
                            state          <= SWAP;
                            o_coeff_update <= 1'b1;
                            for (int k = 0; k < FIR_DEPTH; k++) begin
                                ov_coeff[k*COEFF_WIDTH +: COEFF_WIDTH] <= shadow[k];
                            end
                        end else begin
                            hold_seen <= 1'b1;
                        end
                    end
                    SWAP: begin
                        state  <= IDLE;
                        o_hold <= 1'b0;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Configuration controller for the transposed pipelined FIR datapath.
- Accepts a stream of FIR_DEPTH coefficients over a valid/ready config port into a shadow bank.
- Stalls the deserializer-to-FIR stream, waits for the FIR pipeline to drain, then atomically swaps the shadow bank into the active bank that drives the filter taps.
- Sits beside the FIR instance in the top level; gates the FIR input valid.

Parameters:
COEFF_WIDTH, 24, bit width of one coefficient (matches DATA_WIDTH)
FIR_DEPTH, 16, number of taps/coefficients per bank
DRAIN_TIMEOUT, 255, max DRAIN cycles before forced swap (used only with the optional feature)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  asynchronous, active-low reset
i_en  in  1  global enable; when low, state, counters and banks freeze and o_cfg_ready=0
i_cfg_start  in  1  single-cycle pulse: begin a new coefficient load
iv_cfg_data  in  COEFF_WIDTH  coefficient word
i_cfg_valid  in  1  iv_cfg_data valid
o_cfg_ready  out  1  loader accepts a word this cycle
i_fir_busy  in  1  high while any sample is in flight in the FIR pipeline
o_hold  out  1  stall request; top level ANDs FIR i_din_valid with !o_hold
ov_coeff  out  FIR_DEPTH*COEFF_WIDTH  active bank; coefficient k at [k*COEFF_WIDTH +: COEFF_WIDTH]
o_coeff_update  out  1  one-cycle pulse in the cycle the active bank changes
o_busy  out  1  high in any state other than IDLE
o_abort  out  1  one-cycle pulse when a load is restarted mid-LOAD
o_timeout  out  1  one-cycle pulse on forced swap (optional feature)

Behaviour:
- Reset (i_rst=0, async): state=IDLE, idx=0, shadow and active banks=0, all 1-bit outputs=0, ov_coeff=0.
- FSM states: IDLE, LOAD, DRAIN, SWAP. All outputs are registered except o_cfg_ready, which is 1 exactly when state==LOAD and i_en=1.
- IDLE:
  - i_cfg_start=1 -> LOAD, idx<=0.
  - i_cfg_valid ignored.
- LOAD:
  - Handshake = i_cfg_valid & o_cfg_ready. Each handshake writes shadow[idx]<=iv_cfg_data and sets idx<=idx+1.
  - Handshake with idx==FIR_DEPTH-1 -> DRAIN; idx<=0.
  - i_cfg_start=1 in LOAD restarts the load: idx<=0, pulse o_abort, discard any same-cycle handshake, stay in LOAD. Shadow contents are overwritten on reload.
- DRAIN:
  - o_hold=1 from the first DRAIN cycle.
  - Move to SWAP at the first cycle where i_fir_busy=0 and o_hold has already been 1 for at least one prior cycle. Minimum DRAIN length is 2 cycles; this guarantees no sample was admitted after the hold was sampled.
  - i_cfg_start ignored.
- SWAP (exactly 1 cycle):
  - active<=shadow; o_coeff_update=1 in the same cycle the new ov_coeff appears; o_hold stays 1.
  - Next state IDLE; o_hold returns to 0 the following cycle.
- Latency: final config handshake to o_coeff_update is at least 3 cycles (DRAIN x2, SWAP).
- Active bank changes only in SWAP; it never holds a partial bank.
- i_en=0 in any state: no transitions, no handshakes, no pulses, o_hold holds its value, timeout counter frozen.
- Reset asserted mid-LOAD or mid-DRAIN: immediate return to the reset state; the active bank is zeroed.
- idx width is clog2(FIR_DEPTH); FIR_DEPTH must be at least 2.

Optional Feature:
FIR_COEFF_DRAIN_TIMEOUT_EN
- Defined:
  - An 8+ bit counter clears on DRAIN entry and increments each enabled DRAIN cycle.
  - When it reaches DRAIN_TIMEOUT while i_fir_busy is still 1, go to SWAP anyway and pulse o_timeout in the SWAP cycle together with o_coeff_update.
- Not defined: DRAIN waits indefinitely; o_timeout is tied to 0 and no counter is built.

Test Plan:
- Reset, then i_cfg_start and 16 back-to-back words 1..16 with i_fir_busy=0 -> o_hold high 2 cycles, then o_coeff_update pulses once; ov_coeff[0 +: 24]=1 and ov_coeff[15*24 +: 24]=16; o_busy=0 the next cycle.
- Same load with i_cfg_valid toggled every other cycle -> exactly 16 handshakes, identical final bank.
- After 5 words, pulse i_cfg_start, then send 16 words 0x100..0x10F -> o_abort pulses once; final bank is 0x100..0x10F.
- Complete a load while i_fir_busy=1 for 10 cycles after DRAIN entry -> o_hold=1 throughout; SWAP occurs 1 cycle after busy falls; ov_coeff unchanged until then.
- Drop i_en for 4 cycles mid-LOAD (idx=7) -> o_cfg_ready=0, no writes; load resumes at idx=7 and completes correctly.
- With FIR_COEFF_DRAIN_TIMEOUT_EN defined, DRAIN_TIMEOUT=8, i_fir_busy stuck at 1 -> SWAP after 8 DRAIN cycles; o_timeout and o_coeff_update pulse together; bank updated.
